// File: rtl/instr_fetch_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_buffer_if
//  Purpose  : Bundles the instruction-memory port, the decode handshake and
//             the redirect request of the fetch front end into one interface.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals (directions as seen by the fetch buffer, i.e. the master modport)
//    o_imemAddr    out 32   fetch word address, always word-aligned
//    o_imemReq     out 1    fetch request; data returns the following cycle
//    i_imemData    in  32   instruction word for last cycle's request
//    o_instr       out 32   head-of-FIFO instruction
//    o_instrPC     out 32   PC of o_instr
//    o_instrValid  out 1    FIFO non-empty
//    i_instrReady  in  1    decoder accepts the head entry
//    i_redirect    in  1    flush everything and restart fetch
//    i_redirectPC  in  32   restart address (low two bits ignored)
//    o_count       out CW   current FIFO occupancy
//  Modports
//    master : the fetch buffer
//    slave  : the memory / decoder / redirect side
// ============================================================================
interface instr_fetch_buffer_if #(
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   o_imemAddr;
  logic          o_imemReq;
  logic [31:0]   i_imemData;
  logic [31:0]   o_instr;
  logic [31:0]   o_instrPC;
  logic          o_instrValid;
  logic          i_instrReady;
  logic          i_redirect;
  logic [31:0]   i_redirectPC;
  logic [CW-1:0] o_count;

  modport master (
    output o_imemAddr,
    output o_imemReq,
    input  i_imemData,
    output o_instr,
    output o_instrPC,
    output o_instrValid,
    input  i_instrReady,
    input  i_redirect,
    input  i_redirectPC,
    output o_count
  );

  modport slave (
    input  o_imemAddr,
    input  o_imemReq,
    output i_imemData,
    input  o_instr,
    input  o_instrPC,
    input  o_instrValid,
    output i_instrReady,
    output i_redirect,
    output i_redirectPC,
    input  o_count
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_buffer
//  Purpose  : Instruction fetch front end. Owns the fetch PC, issues
//             sequential word fetches to a 1-cycle-latency synchronous
//             instruction memory, buffers returned {instr, pc} pairs in a
//             DEPTH-entry FIFO and hands them to decode over valid/ready.
//             A redirect flushes the FIFO and any in-flight fetch and
//             restarts fetch at the new PC.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH     FIFO entries (power of two, >= 2; >= 4 for full throughput)
//    RESET_PC  first fetch address after reset (word aligned)
//  Ports
//    i_clock   in  1   clock, rising edge
//    i_reset   in  1   asynchronous active-high reset
//    bus       master modport of instr_fetch_buffer_if (memory port,
//              decode handshake, redirect, occupancy)
// ============================================================================
module instr_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  instr_fetch_buffer_if.master  bus
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  // Occupancy sum (count + inflight) needs one extra bit to hold DEPTH+1.
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]   fetch_pc_q,    fetch_pc_d;
  logic          inflight_q,    inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [AW-1:0] rd_ptr_q,      rd_ptr_d;
  logic [AW-1:0] wr_ptr_q,      wr_ptr_d;
  logic [CW-1:0] count_q,       count_d;

  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_pc_q    [DEPTH];

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic [CW:0] occupancy;
  logic        req;
  logic        push;
  logic        pop;
  logic        valid;

  // A fetch reserves a FIFO slot at issue time, so the in-flight word is
  // counted against capacity. Only registered state is used: a pop in the
  // same cycle does not free a slot until the next cycle.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign req       = !i_reset && !bus.i_redirect && (occupancy < DEPTH_W);

  assign valid     = (count_q != '0);
  // Flush wins over both the returning word and a decode handshake.
  assign push      = inflight_q && !bus.i_redirect;
  assign pop       = valid && bus.i_instrReady && !bus.i_redirect;

  // The low address bits of the redirect target are deliberately dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = &{1'b0, bus.i_redirectPC[1:0]};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = req;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (req) begin
      // 32-bit add wraps naturally from FFFF_FFFC to 0000_0000.
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_pc_d = fetch_pc_q;
    end

    if (bus.i_redirect) begin
      fetch_pc_d = {bus.i_redirectPC[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage. Entries are cleared on reset so the outputs read zero
  // while empty after reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr_q[wr_ptr_q] <= bus.i_imemData;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.o_imemAddr   = fetch_pc_q;
  assign bus.o_imemReq    = req;
  assign bus.o_instr      = fifo_instr_q[rd_ptr_q];
  assign bus.o_instrPC    = fifo_pc_q[rd_ptr_q];
  assign bus.o_instrValid = valid;
  assign bus.o_count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_buffer
//  Purpose  : Self-checking bench for instr_fetch_buffer. Memory word k holds
//             k. Directed scenarios plus randomized ready/redirect traffic
//             compared against a queue-based model of the fetch stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic i_clock;
  logic i_reset;

  instr_fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

  instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Synchronous instruction memory, word k = k. Unrequested cycles return
  // junk so that capturing at the wrong time is visible.
  always @(posedge i_clock) begin
    if (bus.o_imemReq) bus.i_imemData <= bus.o_imemAddr >> 2;
    else               bus.i_imemData <= $urandom;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // --------------------------------------------------------------------------
  // Reference model: queue of words delivered by memory but not yet popped,
  // one pending fetch, next expected fetch address and next expected
  // delivered PC.
  // --------------------------------------------------------------------------
  logic [31:0] mq_instr[$];
  logic [31:0] mq_pc[$];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_deliver;

  function automatic bit model_req();
    return !bus.i_redirect && ((mq_pc.size() + int'(m_pend)) < DEPTH);
  endfunction

  task automatic model_clear(input logic [31:0] pc);
    mq_instr.delete();
    mq_pc.delete();
    m_pend    = 1'b0;
    m_fetch   = pc;
    m_deliver = pc;
  endtask

  // Advance one clock, updating the model from the inputs applied this cycle.
  task automatic tick();
    bit          s_redir, s_req, s_pop;
    logic [31:0] s_rpc;
    s_redir = bus.i_redirect;
    s_rpc   = bus.i_redirectPC;
    s_req   = model_req();
    s_pop   = (mq_pc.size() > 0) && bus.i_instrReady;
    @(posedge i_clock);
    #1;
    if (s_redir) begin
      model_clear({s_rpc[31:2], 2'b00});
    end else begin
      if (s_pop) begin
        void'(mq_pc.pop_front());
        void'(mq_instr.pop_front());
        m_deliver = m_deliver + 32'd4;
      end
      if (m_pend) begin
        mq_instr.push_back(m_pend_pc >> 2);
        mq_pc.push_back(m_pend_pc);
      end
      m_pend = s_req;
      if (s_req) begin
        m_pend_pc = m_fetch;
        m_fetch   = m_fetch + 32'd4;
      end
    end
  endtask

  // Reset and release at posedge+1; the next edge is cycle 0.
  task automatic do_reset();
    bus.i_instrReady = 1'b0;
    bus.i_redirect   = 1'b0;
    bus.i_redirectPC = '0;
    i_reset = 1'b1;
    @(posedge i_clock);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    model_clear(RESET_PC);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    bus.i_instrReady = 1'b1;
    bus.i_redirect   = 1'b0;
    bus.i_redirectPC = '0;
    i_reset = 1'b1;
    @(posedge i_clock);
    #2;
    n_checks++;
    if ({bus.o_imemReq, bus.o_instrValid, bus.o_count} !== '0) begin
      $display("FAIL reset_ctrl: req/valid/count got %b/%b/%0d want 0/0/0",
               bus.o_imemReq, bus.o_instrValid, bus.o_count);
    end else n_pass++;
    n_checks++;
    if (bus.o_imemAddr !== RESET_PC) begin
      $display("FAIL reset_addr: got %h want %h", bus.o_imemAddr, RESET_PC);
    end else n_pass++;
    n_checks++;
    if ({bus.o_instr, bus.o_instrPC} !== 64'h0) begin
      $display("FAIL reset_data: instr/pc got %h/%h want 0/0", bus.o_instr, bus.o_instrPC);
    end else n_pass++;
    i_reset = 1'b0;
    #1;
    n_checks++;
    if (bus.o_imemReq !== 1'b1) begin
      $display("FAIL reset_release_req: got %b want 1", bus.o_imemReq);
    end else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stream();
    do_reset();
    bus.i_instrReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++;
      if ({bus.o_imemReq, bus.o_imemAddr} !== {1'b1, 32'(4 * c)}) begin
        $display("FAIL stream_req c=%0d: req/addr got %b/%h want 1/%h",
                 c, bus.o_imemReq, bus.o_imemAddr, 32'(4 * c));
      end else n_pass++;
      n_checks++;
      if (c < 2) begin
        if (bus.o_instrValid !== 1'b0) begin
          $display("FAIL stream_early c=%0d: valid got %b want 0", c, bus.o_instrValid);
        end else n_pass++;
      end else begin
        if ({bus.o_instrValid, bus.o_instr, bus.o_instrPC} !==
            {1'b1, 32'(c - 2), 32'(4 * (c - 2))}) begin
          $display("FAIL stream_out c=%0d: valid/instr/pc got %b/%h/%h want 1/%h/%h",
                   c, bus.o_instrValid, bus.o_instr, bus.o_instrPC,
                   32'(c - 2), 32'(4 * (c - 2)));
        end else n_pass++;
      end
      tick();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full_stall();
    int nreq;
    do_reset();
    nreq = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.o_imemReq === 1'b1) begin
        n_checks++;
        if (bus.o_imemAddr !== 32'(4 * nreq)) begin
          $display("FAIL stall_addr: got %h want %h", bus.o_imemAddr, 32'(4 * nreq));
        end else n_pass++;
        nreq++;
      end
      tick();
    end
    #1;
    n_checks++;
    if (nreq != 4) begin
      $display("FAIL stall_nreq: got %0d want 4", nreq);
    end else n_pass++;
    n_checks++;
    if ({bus.o_count, bus.o_imemReq} !== {3'd4, 1'b0}) begin
      $display("FAIL stall_full: count/req got %0d/%b want 4/0", bus.o_count, bus.o_imemReq);
    end else n_pass++;
    // Raise ready: no same-cycle credit, so no request yet.
    bus.i_instrReady = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_imemReq, bus.o_instrValid, bus.o_instr, bus.o_instrPC} !==
        {1'b0, 1'b1, 32'd0, 32'd0}) begin
      $display("FAIL stall_rise: req/valid/instr/pc got %b/%b/%h/%h want 0/1/0/0",
               bus.o_imemReq, bus.o_instrValid, bus.o_instr, bus.o_instrPC);
    end else n_pass++;
    tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++;
      if ({bus.o_instrValid, bus.o_instr, bus.o_instrPC} !== {1'b1, 32'(i), 32'(4 * i)}) begin
        $display("FAIL stall_drain i=%0d: valid/instr/pc got %b/%h/%h want 1/%h/%h",
                 i, bus.o_instrValid, bus.o_instr, bus.o_instrPC, 32'(i), 32'(4 * i));
      end else n_pass++;
      if (i == 1) begin
        n_checks++;
        if ({bus.o_imemReq, bus.o_imemAddr} !== {1'b1, 32'd16}) begin
          $display("FAIL stall_resume: req/addr got %b/%h want 1/10",
                   bus.o_imemReq, bus.o_imemAddr);
        end else n_pass++;
      end
      tick();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_redirect_inflight();
    logic [31:0] pc;
    do_reset();
    bus.i_instrReady = 1'b1;
    bus.i_redirectPC = 32'h100;
    for (int c = 0; c < 13; c++) begin
      bus.i_redirect = (c == 5);
      #1;
      if (c == 5) begin
        n_checks++;
        if (bus.o_imemReq !== 1'b0) begin
          $display("FAIL redir_req_low: got %b want 0", bus.o_imemReq);
        end else n_pass++;
      end else if (c == 6) begin
        n_checks++;
        if ({bus.o_count, bus.o_instrValid, bus.o_imemReq, bus.o_imemAddr} !==
            {3'd0, 1'b0, 1'b1, 32'h100}) begin
          $display("FAIL redir_flush: count/valid/req/addr got %0d/%b/%b/%h want 0/0/1/100",
                   bus.o_count, bus.o_instrValid, bus.o_imemReq, bus.o_imemAddr);
        end else n_pass++;
      end else if (c == 7) begin
        n_checks++;
        if (bus.o_instrValid !== 1'b0) begin
          $display("FAIL redir_gap: valid got %b want 0", bus.o_instrValid);
        end else n_pass++;
      end else if (c >= 8) begin
        pc = 32'h100 + 32'(4 * (c - 8));
        n_checks++;
        if ({bus.o_instrValid, bus.o_instrPC, bus.o_instr} !== {1'b1, pc, pc >> 2}) begin
          $display("FAIL redir_target c=%0d: valid/pc/instr got %b/%h/%h want 1/%h/%h",
                   c, bus.o_instrValid, bus.o_instrPC, bus.o_instr, pc, pc >> 2);
        end else n_pass++;
      end
      tick();
    end
    bus.i_redirect = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_redirect_pop();
    do_reset();
    bus.i_instrReady = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    bus.i_redirect   = 1'b1;
    bus.i_redirectPC = 32'h203;
    #1;
    n_checks++;
    if (bus.o_instrValid !== 1'b1) begin
      $display("FAIL rpop_pre: valid got %b want 1", bus.o_instrValid);
    end else n_pass++;
    tick();
    bus.i_redirect = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_count, bus.o_instrValid, bus.o_imemReq, bus.o_imemAddr} !==
        {3'd0, 1'b0, 1'b1, 32'h200}) begin
      $display("FAIL rpop_restart: count/valid/req/addr got %0d/%b/%b/%h want 0/0/1/200",
               bus.o_count, bus.o_instrValid, bus.o_imemReq, bus.o_imemAddr);
    end else n_pass++;
    tick();
    #1;
    n_checks++;
    if (bus.o_instrValid !== 1'b0) begin
      $display("FAIL rpop_gap: valid got %b want 0", bus.o_instrValid);
    end else n_pass++;
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if ({bus.o_instrValid, bus.o_instrPC} !== {1'b1, 32'h200 + 32'(4 * k)}) begin
        $display("FAIL rpop_stream k=%0d: valid/pc got %b/%h want 1/%h",
                 k, bus.o_instrValid, bus.o_instrPC, 32'h200 + 32'(4 * k));
      end else n_pass++;
      tick();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    do_reset();
    bus.i_instrReady = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.i_redirect   = (c == 2) || (c == 3);
      bus.i_redirectPC = (c == 2) ? 32'h40 : 32'h80;
      #1;
      if (c == 4) begin
        n_checks++;
        if ({bus.o_imemReq, bus.o_imemAddr} !== {1'b1, 32'h80}) begin
          $display("FAIL b2b_addr: req/addr got %b/%h want 1/80", bus.o_imemReq, bus.o_imemAddr);
        end else n_pass++;
      end else if (c == 6) begin
        n_checks++;
        if ({bus.o_instrValid, bus.o_instrPC} !== {1'b1, 32'h80}) begin
          $display("FAIL b2b_out: valid/pc got %b/%h want 1/80", bus.o_instrValid, bus.o_instrPC);
        end else n_pass++;
      end
      tick();
    end
    bus.i_redirect = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_pc_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    exp_pc[3] = 32'h0000_0004;
    do_reset();
    bus.i_instrReady = 1'b1;
    bus.i_redirectPC = 32'hFFFF_FFF8;
    for (int c = 0; c < 7; c++) begin
      bus.i_redirect = (c == 0);
      #1;
      if (c == 3) begin
        n_checks++;
        if (bus.o_imemAddr !== 32'h0) begin
          $display("FAIL wrap_addr: got %h want 0", bus.o_imemAddr);
        end else n_pass++;
      end
      if (c >= 3) begin
        n_checks++;
        if ({bus.o_instrValid, bus.o_instrPC} !== {1'b1, exp_pc[c - 3]}) begin
          $display("FAIL wrap_pc c=%0d: valid/pc got %b/%h want 1/%h",
                   c, bus.o_instrValid, bus.o_instrPC, exp_pc[c - 3]);
        end else n_pass++;
      end
      tick();
    end
    bus.i_redirect = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 4; c++) tick();
    #1;
    n_checks++;
    if (bus.o_count !== 3'd3) begin
      $display("FAIL areset_pre: count got %0d want 3", bus.o_count);
    end else n_pass++;
    #1;
    i_reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_instrValid, bus.o_count, bus.o_imemReq} !== {1'b0, 3'd0, 1'b0}) begin
      $display("FAIL areset_ctrl: valid/count/req got %b/%0d/%b want 0/0/0",
               bus.o_instrValid, bus.o_count, bus.o_imemReq);
    end else n_pass++;
    n_checks++;
    if (bus.o_imemAddr !== RESET_PC) begin
      $display("FAIL areset_addr: got %h want %h", bus.o_imemAddr, RESET_PC);
    end else n_pass++;
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    model_clear(RESET_PC);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.i_instrReady = ($urandom_range(0, 3) != 0);
      bus.i_redirect   = ($urandom_range(0, 19) == 0);
      bus.i_redirectPC = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
      #1;
      n_checks++;
      if ({bus.o_count, bus.o_instrValid} !== {3'(mq_pc.size()), mq_pc.size() != 0}) begin
        $display("FAIL rnd_count c=%0d: count/valid got %0d/%b want %0d/%b",
                 c, bus.o_count, bus.o_instrValid, mq_pc.size(), mq_pc.size() != 0);
      end else n_pass++;
      n_checks++;
      if ({bus.o_imemReq, bus.o_imemAddr} !== {model_req(), m_fetch}) begin
        $display("FAIL rnd_fetch c=%0d: req/addr got %b/%h want %b/%h",
                 c, bus.o_imemReq, bus.o_imemAddr, model_req(), m_fetch);
      end else n_pass++;
      if (mq_pc.size() > 0) begin
        n_checks++;
        if ({bus.o_instrPC, bus.o_instr} !== {m_deliver, m_deliver >> 2}) begin
          $display("FAIL rnd_head c=%0d: pc/instr got %h/%h want %h/%h",
                   c, bus.o_instrPC, bus.o_instr, m_deliver, m_deliver >> 2);
        end else n_pass++;
      end
      tick();
    end
    bus.i_redirect = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  initial begin
    i_reset          = 1'b1;
    bus.i_instrReady = 1'b0;
    bus.i_redirect   = 1'b0;
    bus.i_redirectPC = '0;
    model_clear(RESET_PC);
    test_reset();
    test_stream();
    test_full_stall();
    test_redirect_inflight();
    test_redirect_pop();
    test_back_to_back();
    test_pc_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
